// File: rtl/sram_arbiter.sv
// Round-robin arbiter in front of a single SRAM controller port: latches the
// winning command, holds it for the whole transaction and inserts a request gap.
module sram_arbiter #(
   parameter int NUM_PORTS = 4
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   input  logic [NUM_PORTS-1:0]   i_request,
   input  logic [NUM_PORTS-1:0]   i_rw,
   input  logic [NUM_PORTS*32-1:0] i_address,
   input  logic [NUM_PORTS*32-1:0] i_wdata,
   input  logic [NUM_PORTS*4-1:0] i_wmask,
   output logic [31:0]            o_rdata,
   output logic [NUM_PORTS-1:0]   o_ready,
   output logic                   o_busy,
   output logic [2:0]             o_grant,
   output logic                   o_sram_request,
   output logic                   o_sram_rw,
   output logic [31:0]            o_sram_address,
   output logic [31:0]            o_sram_wdata,
   output logic [3:0]             o_sram_wmask,
   input  logic [31:0]            i_sram_rdata,
   input  logic                   i_sram_ready
);

   localparam int MAXP = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t                 state_q;
   logic [2:0]             last_q;
   logic [2:0]             grant_q;
   logic                   rw_q;
   logic [31:0]            addr_q;
   logic [31:0]            wdata_q;
   logic [3:0]             wmask_q;
   logic [31:0]            rdata_q;
   logic [NUM_PORTS-1:0]   ready_q;

   // Requests padded to eight entries so a 3-bit index never leaves range.
   logic [MAXP-1:0]        req_pad;
   logic [MAXP-1:0]        rw_pad;
   logic [31:0]            addr_arr  [MAXP];
   logic [31:0]            wdata_arr [MAXP];
   logic [3:0]             wmask_arr [MAXP];
   logic [NUM_PORTS-1:0]   grant_onehot;

   genvar gi;
   generate
      for (gi = 0; gi < MAXP; gi++) begin : g_pad
         if (gi < NUM_PORTS) begin : g_used
            assign req_pad[gi]   = i_request[gi];
            assign rw_pad[gi]    = i_rw[gi];
            assign addr_arr[gi]  = i_address[32*gi +: 32];
            assign wdata_arr[gi] = i_wdata[32*gi +: 32];
            assign wmask_arr[gi] = i_wmask[4*gi +: 4];
         end else begin : g_unused
            assign req_pad[gi]   = 1'b0;
            assign rw_pad[gi]    = 1'b0;
            assign addr_arr[gi]  = 32'd0;
            assign wdata_arr[gi] = 32'd0;
            assign wmask_arr[gi] = 4'd0;
         end
      end
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
         assign grant_onehot[gi] = (grant_q == 3'(gi));
      end
   endgenerate

   // First requester after the last winner, wrapping round the port count.
   logic       found_d;
   logic [2:0] winner_d;
   logic [3:0] cand_d;

   always_comb begin
      found_d  = 1'b0;
      winner_d = last_q;
      cand_d   = 4'd0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand_d = {1'b0, last_q} + 4'(k);
         if (cand_d >= 4'(NUM_PORTS)) begin
            cand_d = cand_d - 4'(NUM_PORTS);
         end
         if (!found_d && req_pad[cand_d[2:0]]) begin
            found_d  = 1'b1;
            winner_d = cand_d[2:0];
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         last_q  <= 3'(NUM_PORTS - 1);
         grant_q <= 3'd0;
         rw_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wmask_q <= 4'd0;
         rdata_q <= 32'd0;
         ready_q <= '0;
      end else begin
         ready_q <= '0;
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  rw_q    <= rw_pad[winner_d];
                  addr_q  <= addr_arr[winner_d];
                  wdata_q <= wdata_arr[winner_d];
                  wmask_q <= wmask_arr[winner_d];
                  grant_q <= winner_d;
                  last_q  <= winner_d;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (i_sram_ready) begin
                  rdata_q <= i_sram_rdata;
                  ready_q <= grant_onehot;
                  state_q <= RELEASE;
               end
            end
            RELEASE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_sram_request = (state_q == BUSY);
   assign o_busy         = (state_q != IDLE);
   assign o_sram_rw      = rw_q;
   assign o_sram_address = addr_q;
   assign o_sram_wdata   = wdata_q;
   assign o_sram_wmask   = wmask_q;
   assign o_rdata        = rdata_q;
   assign o_ready        = ready_q;
   assign o_grant        = grant_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scenario bench for sram_arbiter with a counting SRAM controller model and a
// transaction-level reference model for randomized traffic.
module tb_sram_arbiter;
   localparam int N = 4;
   localparam int C = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   req, rw;
   logic [31:0]    addr_a [N];
   logic [31:0]    wdata_a [N];
   logic [3:0]     wmask_a [N];
   logic [N*32-1:0] addr_bus, wdata_bus;
   logic [N*4-1:0] wmask_bus;

   logic [31:0]  o_rdata, o_sram_address, o_sram_wdata, sram_rdata;
   logic [N-1:0] o_ready;
   logic         o_busy, o_sram_request, o_sram_rw, sram_ready;
   logic [2:0]   o_grant;
   logic [3:0]   o_sram_wmask;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_pack
         assign addr_bus[32*gi +: 32]  = addr_a[gi];
         assign wdata_bus[32*gi +: 32] = wdata_a[gi];
         assign wmask_bus[4*gi +: 4]   = wmask_a[gi];
      end
   endgenerate

   sram_arbiter #(.NUM_PORTS(N)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_request(req), .i_rw(rw),
      .i_address(addr_bus), .i_wdata(wdata_bus), .i_wmask(wmask_bus),
      .o_rdata(o_rdata), .o_ready(o_ready), .o_busy(o_busy), .o_grant(o_grant),
      .o_sram_request(o_sram_request), .o_sram_rw(o_sram_rw),
      .o_sram_address(o_sram_address), .o_sram_wdata(o_sram_wdata),
      .o_sram_wmask(o_sram_wmask), .i_sram_rdata(sram_rdata),
      .i_sram_ready(sram_ready)
   );

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
   endfunction

   // Controller: ready on the (C+1)th cycle of a continuous request.
   int cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= 0;
      else        cnt <= o_sram_request ? cnt + 1 : 0;
   end
   assign sram_ready = o_sram_request && (cnt == C);
   assign sram_rdata = mem_f(o_sram_address);

   int vectors = 0;
   int miscompares = 0;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      req = '0;
      rw = '0;
      for (int p = 0; p < N; p++) begin
         addr_a[p] = 32'd0; wdata_a[p] = 32'd0; wmask_a[p] = 4'd0;
      end
      tick; tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick;
      vectors++;
      if ({o_sram_request, o_sram_rw, o_busy, o_ready} !== '0) begin
         miscompares++;
         $display("FAIL reset_ctrl got req=%b rw=%b busy=%b ready=%b want all 0",
                  o_sram_request, o_sram_rw, o_busy, o_ready);
      end
      vectors++;
      if ({o_sram_address, o_sram_wdata, o_sram_wmask, o_rdata} !== '0) begin
         miscompares++;
         $display("FAIL reset_data got addr=%h wdata=%h wmask=%h rdata=%h want 0",
                  o_sram_address, o_sram_wdata, o_sram_wmask, o_rdata);
      end
      vectors++;
      if (o_grant !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_grant got %0d want 0", o_grant);
      end
   endtask

   task automatic test_single_read;
      do_reset;
      req[0] = 1'b1; rw[0] = 1'b0; addr_a[0] = 32'h0000_0010;
      for (int t = 1; t <= 8; t++) begin
         tick;
         vectors++;
         if (o_sram_request !== (t >= 1 && t <= 5)) begin
            miscompares++;
            $display("FAIL single_req cycle %0d got %b want %b", t, o_sram_request, (t >= 1 && t <= 5));
         end
         vectors++;
         if (o_ready !== ((t == 6) ? 4'b0001 : 4'b0000)) begin
            miscompares++;
            $display("FAIL single_ready cycle %0d got %b", t, o_ready);
         end
         if (t == 1 || t == 6 || t == 8) begin
            vectors++;
            if ((t == 1 && o_sram_address !== 32'h10) || (t != 1 && o_rdata !== 32'hDEAD_BEEF)) begin
               miscompares++;
               $display("FAIL single_data cycle %0d got addr=%h rdata=%h want 10/deadbeef",
                        t, o_sram_address, o_rdata);
            end
         end
         if (t == 6) req[0] = 1'b0;
      end
   endtask

   task automatic test_all_ports;
      logic prev;
      int   low, ng;
      do_reset;
      for (int p = 0; p < N; p++) begin
         req[p] = 1'b1; addr_a[p] = 32'h100 * (p + 1);
      end
      prev = 1'b0; low = 0; ng = 0;
      for (int t = 0; t < 80 && ng < 5; t++) begin
         tick;
         if (o_sram_request && !prev) begin
            vectors++;
            if (o_grant !== 3'(ng % N)) begin
               miscompares++;
               $display("FAIL rr_order grant#%0d got %0d want %0d", ng, o_grant, ng % N);
            end
            if (ng > 0) begin
               vectors++;
               if (low != 2) begin
                  miscompares++;
                  $display("FAIL rr_gap grant#%0d got %0d low cycles want 2", ng, low);
               end
            end
            ng++;
         end
         low = o_sram_request ? 0 : low + 1;
         prev = o_sram_request;
      end
      vectors++;
      if (ng != 5) begin
         miscompares++;
         $display("FAIL rr_timeout got %0d grants want 5", ng);
      end
      req = '0;
      repeat (10) tick;
   endtask

   task automatic test_write_hold;
      do_reset;
      req[2] = 1'b1; rw[2] = 1'b1; addr_a[2] = 32'h200;
      wdata_a[2] = 32'h1234_5678; wmask_a[2] = 4'h3;
      for (int t = 1; t <= 7; t++) begin
         tick;
         if (t == 1) begin
            addr_a[2] = 32'hFFFF_0000; wdata_a[2] = 32'hCAFE_F00D; wmask_a[2] = 4'hC;
         end
         if (t <= 5) begin
            vectors++;
            if ({o_sram_request, o_sram_rw, o_sram_address, o_sram_wdata, o_sram_wmask, o_grant}
                !== {1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'h3, 3'd2}) begin
               miscompares++;
               $display("FAIL write_hold cycle %0d got req=%b rw=%b addr=%h wdata=%h mask=%h grant=%0d",
                        t, o_sram_request, o_sram_rw, o_sram_address, o_sram_wdata, o_sram_wmask, o_grant);
            end
         end
         if (t == 6) begin
            vectors++;
            if (o_ready !== 4'b0100) begin
               miscompares++;
               $display("FAIL write_ready got %b want 0100", o_ready);
            end
            req[2] = 1'b0;
         end
      end
   endtask

   task automatic test_drop_mid_busy;
      do_reset;
      req[1] = 1'b1; rw[1] = 1'b0; addr_a[1] = 32'h40;
      for (int t = 1; t <= 12; t++) begin
         tick;
         if (t == 2) req[1] = 1'b0;
         vectors++;
         if (o_ready !== ((t == 6) ? 4'b0010 : 4'b0000)) begin
            miscompares++;
            $display("FAIL drop_ready cycle %0d got %b", t, o_ready);
         end
         if (t >= 7) begin
            vectors++;
            if (o_sram_request !== 1'b0 || o_busy !== 1'b0) begin
               miscompares++;
               $display("FAIL drop_idle cycle %0d got req=%b busy=%b want 0 0", t, o_sram_request, o_busy);
            end
         end
      end
   endtask

   task automatic test_reset_busy;
      int waited;
      do_reset;
      req[0] = 1'b1; addr_a[0] = 32'h10; addr_a[1] = 32'h20;
      tick; tick;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({o_sram_request, o_ready, o_busy} !== '0) begin
         miscompares++;
         $display("FAIL rstbusy_outputs got req=%b ready=%b busy=%b want 0",
                  o_sram_request, o_ready, o_busy);
      end
      req = '0;
      tick;
      rst_n = 1'b1;
      req = 4'b0011;
      tick;
      vectors++;
      if (o_sram_request !== 1'b1 || o_grant !== 3'd0) begin
         miscompares++;
         $display("FAIL rstbusy_first got req=%b grant=%0d want 1 0", o_sram_request, o_grant);
      end
      waited = 0;
      while (o_ready == '0 && waited < 20) begin
         tick;
         waited++;
      end
      req = '0;
      vectors++;
      if (o_ready !== 4'b0001) begin
         miscompares++;
         $display("FAIL rstbusy_done got ready=%b want 0001", o_ready);
      end
      repeat (4) tick;
   endtask

   task automatic test_back_to_back;
      logic [N-1:0] prev_ready;
      int last_t, nr;
      do_reset;
      req[3] = 1'b1; addr_a[3] = 32'h300;
      prev_ready = '0; last_t = -1; nr = 0;
      for (int t = 0; t < 60 && nr < 3; t++) begin
         tick;
         if (o_ready != '0) begin
            vectors++;
            if (o_ready !== 4'b1000 || o_grant !== 3'd3 || prev_ready !== '0) begin
               miscompares++;
               $display("FAIL b2b_ready got ready=%b grant=%0d prev=%b want 1000 3 0000",
                        o_ready, o_grant, prev_ready);
            end
            if (last_t >= 0) begin
               vectors++;
               if (t - last_t != C + 3) begin
                  miscompares++;
                  $display("FAIL b2b_spacing got %0d want %0d", t - last_t, C + 3);
               end
            end
            last_t = t;
            nr++;
         end
         prev_ready = o_ready;
      end
      vectors++;
      if (nr != 3) begin
         miscompares++;
         $display("FAIL b2b_timeout got %0d completions want 3", nr);
      end
      req = '0;
      repeat (4) tick;
   endtask

   task automatic new_cmd(input int p);
      rw[p] = 1'($urandom);
      addr_a[p] = $urandom;
      wdata_a[p] = $urandom;
      wmask_a[p] = 4'($urandom);
   endtask

   task automatic test_random;
      int m_last, m_port, gc, free_t, w;
      logic have_g, have_rd, in_busy, rel;
      logic m_rw;
      logic [31:0] m_addr, m_wdata, exp_rd;
      logic [3:0] m_wmask;
      logic [N-1:0] exp_ready;
      do_reset;
      m_last = N - 1; m_port = 0; gc = -100; free_t = 0;
      have_g = 1'b0; have_rd = 1'b0; exp_rd = 32'd0;
      m_rw = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_wmask = 4'd0;
      for (int t = 0; t < 800; t++) begin
         tick;
         in_busy = (t >= gc) && (t <= gc + C);
         rel = (t == gc + C + 1);
         exp_ready = rel ? (N'(1) << m_port) : '0;
         if (rel) begin
            exp_rd = mem_f(m_addr);
            have_rd = 1'b1;
         end
         vectors++;
         if ({o_sram_request, o_busy, o_ready} !== {in_busy, in_busy | rel, exp_ready}) begin
            miscompares++;
            $display("FAIL rand_ctrl cycle %0d got req=%b busy=%b ready=%b want %b %b %b",
                     t, o_sram_request, o_busy, o_ready, in_busy, in_busy | rel, exp_ready);
         end
         if (in_busy) begin
            vectors++;
            if ({o_sram_rw, o_sram_address, o_sram_wdata, o_sram_wmask} !== {m_rw, m_addr, m_wdata, m_wmask}) begin
               miscompares++;
               $display("FAIL rand_cmd cycle %0d got %b %h %h %h want %b %h %h %h", t,
                        o_sram_rw, o_sram_address, o_sram_wdata, o_sram_wmask, m_rw, m_addr, m_wdata, m_wmask);
            end
         end
         if (have_g) begin
            vectors++;
            if (o_grant !== 3'(m_port)) begin
               miscompares++;
               $display("FAIL rand_grant cycle %0d got %0d want %0d", t, o_grant, m_port);
            end
         end
         if (have_rd) begin
            vectors++;
            if (o_rdata !== exp_rd) begin
               miscompares++;
               $display("FAIL rand_rdata cycle %0d got %h want %h", t, o_rdata, exp_rd);
            end
         end
         for (int p = 0; p < N; p++) begin
            if (rel && p == m_port) begin
               if ($urandom_range(2) == 0) new_cmd(p);
               else req[p] = 1'b0;
            end else if (!req[p]) begin
               if ($urandom_range(5) == 0) begin
                  req[p] = 1'b1;
                  new_cmd(p);
               end
            end else if ($urandom_range(3) == 0) begin
               wdata_a[p] = $urandom;
            end
         end
         if (t >= free_t && req != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
               if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
            end
            m_port = w; m_last = w;
            m_rw = rw[w]; m_addr = addr_a[w]; m_wdata = wdata_a[w]; m_wmask = wmask_a[w];
            gc = t + 1;
            free_t = t + C + 3;
            have_g = 1'b1;
         end
      end
      req = '0;
      repeat (10) tick;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      req = '0;
      rw = '0;
      for (int p = 0; p < N; p++) begin
         addr_a[p] = 32'd0; wdata_a[p] = 32'd0; wmask_a[p] = 4'd0;
      end
      test_reset;
      test_single_read;
      test_all_ports;
      test_write_hold;
      test_drop_mid_busy;
      test_reset_busy;
      test_back_to_back;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
